// File: rtl/sprite_draw_engine.sv
// Sprite pixel writer for the 160x120 framebuffer: it erases the previous sprite, then draws the new one, one pixel per clock.
// Optional build macro SPRITE_CLIP_EN suppresses plot for pixels that fall off the visible screen.
module sprite_draw_engine #(
  parameter int         SPRITE_W      = 8,
  parameter int         SPRITE_H      = 8,
  parameter logic [2:0] SPRITE_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter int         SCREEN_W      = 160,
  parameter int         SCREEN_H      = 120
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic [7:0] new_x,
  input  logic [6:0] new_y,
  output logic [7:0] x_coord,
  output logic [6:0] y_coord,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

`ifdef SPRITE_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  localparam logic [3:0] LAST_X = 4'(SPRITE_W - 1);
  localparam logic [3:0] LAST_Y = 4'(SPRITE_H - 1);
  localparam logic [8:0] SCR_W  = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H  = 8'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       vis;
  } pixel_t;

  // Sums are formed one bit wider than the outputs so the clip test sees true off-screen positions.
  function automatic pixel_t place(input logic [7:0] ox, input logic [6:0] oy,
                                   input logic [3:0] xo, input logic [3:0] yo);
    pixel_t     p;
    logic [8:0] sx;
    logic [7:0] sy;
    sx    = {1'b0, ox} + {5'b0, xo};
    sy    = {1'b0, oy} + {4'b0, yo};
    p.x   = sx[7:0];
    p.y   = sy[6:0];
    p.vis = !CLIP || ((sx < SCR_W) && (sy < SCR_H));
    return p;
  endfunction

  state_t     state;
  logic [7:0] base_x, old_x;
  logic [6:0] base_y, old_y;
  logic       have_drawn;
  logic [3:0] x_off, y_off;

  logic       last_px;
  logic [3:0] nx_off, ny_off;
  pixel_t     start_px, erase_nx, draw_first, draw_nx;

  // NOTE: always_comb assigns every output on every path, so no latch can be inferred.
  always_comb begin
    last_px    = (x_off == LAST_X) && (y_off == LAST_Y);
    nx_off     = (x_off == LAST_X) ? 4'd0 : x_off + 4'd1;
    ny_off     = (x_off == LAST_X) ? y_off + 4'd1 : y_off;
    start_px   = have_drawn ? place(old_x, old_y, 4'd0, 4'd0)
                            : place(new_x, new_y, 4'd0, 4'd0);
    erase_nx   = place(old_x, old_y, nx_off, ny_off);
    draw_first = place(base_x, base_y, 4'd0, 4'd0);
    draw_nx    = place(base_x, base_y, nx_off, ny_off);
  end

  // NOTE: state and outputs use non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      x_coord    <= '0;
      y_coord    <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      base_x     <= '0;
      base_y     <= '0;
      old_x      <= '0;
      old_y      <= '0;
      have_drawn <= 1'b0;
      x_off      <= '0;
      y_off      <= '0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            base_x  <= new_x;
            base_y  <= new_y;
            x_off   <= '0;
            y_off   <= '0;
            busy    <= 1'b1;
            {x_coord, y_coord, plot} <= {start_px.x, start_px.y, start_px.vis};
            colour  <= have_drawn ? BG_COLOUR : SPRITE_COLOUR;
            state   <= have_drawn ? ERASE : DRAW;
          end
        end
        ERASE: begin
          if (last_px) begin
            x_off  <= '0;
            y_off  <= '0;
            {x_coord, y_coord, plot} <= {draw_first.x, draw_first.y, draw_first.vis};
            colour <= SPRITE_COLOUR;
            state  <= DRAW;
          end else begin
            x_off  <= nx_off;
            y_off  <= ny_off;
            {x_coord, y_coord, plot} <= {erase_nx.x, erase_nx.y, erase_nx.vis};
          end
        end
        DRAW: begin
          if (last_px) begin
            plot       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            old_x      <= base_x;
            old_y      <= base_y;
            have_drawn <= 1'b1;
            state      <= DONE;
          end else begin
            x_off <= nx_off;
            y_off <= ny_off;
            {x_coord, y_coord, plot} <= {draw_nx.x, draw_nx.y, draw_nx.vis};
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Self-checking bench for sprite_draw_engine: table of requests, hand sequences, then random requests
// against a loop-based pixel model. Honours SPRITE_CLIP_EN.
module tb_sprite_draw_engine;

  logic       clock = 1'b0;
  logic       resetn, start;
  logic [7:0] new_x;
  logic [6:0] new_y;
  logic [7:0] x_coord;
  logic [6:0] y_coord;
  logic [2:0] colour;
  logic       plot, busy, done;

  sprite_draw_engine dut (
    .clock(clock), .resetn(resetn), .start(start), .new_x(new_x), .new_y(new_y),
    .x_coord(x_coord), .y_coord(y_coord), .colour(colour), .plot(plot),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  localparam int W = 8, H = 8;

  typedef struct {
    int x;
    int y;
    int c;
    bit p;
  } px_t;

  typedef struct {
    int nx;
    int ny;
    int exp_busy;
    int exp_plots;
  } req_t;

  int n_checks = 0, n_fail = 0;
  int m_old_x = 0, m_old_y = 0;
  bit m_have = 1'b0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit visible(input int x, input int y);
`ifdef SPRITE_CLIP_EN
    return (x < 160) && (y < 120);
`else
    return 1'b1;
`endif
  endfunction

  // Reference: erase pass over the previous origin (if any), then draw pass over the new origin.
  task automatic run_request(input int nx, input int ny, input bit glitch,
                             output int busy_cycles, output int plots);
    px_t q[$];
    if (m_have)
      for (int yo = 0; yo < H; yo++)
        for (int xo = 0; xo < W; xo++)
          q.push_back('{(m_old_x + xo) % 256, (m_old_y + yo) % 128, 0,
                        visible(m_old_x + xo, m_old_y + yo)});
    for (int yo = 0; yo < H; yo++)
      for (int xo = 0; xo < W; xo++)
        q.push_back('{(nx + xo) % 256, (ny + yo) % 128, 6, visible(nx + xo, ny + yo)});

    start = 1'b1;
    new_x = 8'(nx);
    new_y = 7'(ny);
    busy_cycles = 0;
    plots = 0;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clock);
      start = glitch && ((k + 1 == 5) || (k + 1 == 64));
      new_x = 8'($urandom);
      new_y = 7'($urandom);
      if (busy === 1'b1) busy_cycles++;
      if (plot === 1'b1) plots++;
      check("plot", plot, q[k].p);
      check("done_low", done, 0);
      if (q[k].p) begin
        check("x_coord", x_coord, q[k].x);
        check("y_coord", y_coord, q[k].y);
        check("colour", colour, q[k].c);
      end
    end
    @(negedge clock);
    start = glitch;
    check("done_pulse", done, 1);
    check("done_plot", plot, 0);
    check("done_busy", busy, 0);
    if (q[q.size()-1].p) begin
      check("hold_x", x_coord, q[q.size()-1].x);
      check("hold_y", y_coord, q[q.size()-1].y);
      check("hold_colour", colour, 6);
    end
    m_old_x = nx;
    m_old_y = ny;
    m_have  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_plot", plot, 0);
    if (glitch) begin
      @(negedge clock);
      check("no_queue_busy", busy, 0);
      check("no_queue_plot", plot, 0);
    end
  endtask

  req_t tbl[5];

  initial begin
    int bc, pc;
`ifdef SPRITE_CLIP_EN
    tbl[0] = '{10, 20, 64, 64};
    tbl[1] = '{12, 20, 128, 128};
    tbl[2] = '{156, 116, 128, 80};
    tbl[3] = '{0, 0, 128, 80};
    tbl[4] = '{155, 115, 128, 89};
`else
    tbl[0] = '{10, 20, 64, 64};
    tbl[1] = '{12, 20, 128, 128};
    tbl[2] = '{156, 116, 128, 128};
    tbl[3] = '{0, 0, 128, 128};
    tbl[4] = '{155, 115, 128, 128};
`endif

    resetn = 1'b0;
    start  = 1'b0;
    new_x  = '0;
    new_y  = '0;
    repeat (2) @(negedge clock);
    check("rst_x", x_coord, 0);
    check("rst_y", y_coord, 0);
    check("rst_colour", colour, 0);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    resetn = 1'b1;
    @(negedge clock);

    // Each request starts in the cycle right after the previous done.
    foreach (tbl[i]) begin
      run_request(tbl[i].nx, tbl[i].ny, 1'b0, bc, pc);
      check("busy_cycles", bc, tbl[i].exp_busy);
      check("plot_count", pc, tbl[i].exp_plots);
    end

    // Reset in cycle 30 of a draw pass, after idling so this draw carries an erase first.
    @(negedge clock);
    start = 1'b1;
    new_x = 8'd50;
    new_y = 7'd50;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    check("pre_reset_busy", busy, 1);
    resetn = 1'b0;
    #1;
    check("async_x", x_coord, 0);
    check("async_y", y_coord, 0);
    check("async_colour", colour, 0);
    check("async_plot", plot, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    @(negedge clock);
    resetn = 1'b1;
    m_have = 1'b0;
    @(negedge clock);

    // Draw-only pass with start pulsed in cycles 5, 64 and the done cycle.
    run_request(40, 40, 1'b1, bc, pc);
    check("glitch_busy_cycles", bc, 64);
    check("glitch_plot_count", pc, 64);
    run_request(60, 30, 1'b0, bc, pc);
    check("erase_after_glitch", bc, 128);

    for (int r = 0; r < 6; r++)
      run_request(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)), 1'b0, bc, pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
